// File: rtl/sram_layer1_weight_loader_pkg.sv
// Shared definitions for the layer-1 weight SRAM loader.
//   state_t / ST_*  : loader FSM encoding (IDLE, LOAD, WRITE, DONE)
//   cnt_width()     : counter width for a modulus n (at least 1 bit)
//   beats_of()      : stream beats per SRAM word
package sram_layer1_weight_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beats_of(input int sram_w, input int in_w);
    return sram_w / in_w;
  endfunction

endpackage

// File: rtl/sram_layer1_weight_loader_packer.sv
// weight_beat_packer: assembles IN_WIDTH-bit beats into one WORD_WIDTH-bit
// SRAM word, first beat in the LSBs.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clear         synchronous discard of the partial word and beat count
//   accept        a beat is being taken this cycle
//   data          the beat
//   word          packed word including the beat being accepted this cycle
//   word_full     the accepted beat completes the word
module weight_beat_packer
  import sram_layer1_weight_loader_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int WORD_WIDTH = 160
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [IN_WIDTH-1:0]   data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int BEATS  = beats_of(WORD_WIDTH, IN_WIDTH);
  localparam int BEAT_W = cnt_width(BEATS);

  logic [WORD_WIDTH-1:0] pack;
  logic [BEAT_W-1:0]     beat_cnt;

  assign word_full = accept && (beat_cnt == BEAT_W'(BEATS - 1));

  // Word as it will look after this cycle's beat lands; lets the top
  // register the complete word on the same edge that accepts the last beat.
  always_comb begin
    word = pack;
    if (accept) begin
      word[beat_cnt*IN_WIDTH +: IN_WIDTH] = data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack     <= '0;
      beat_cnt <= '0;
    end else if (clear) begin
      pack     <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      pack     <= word;
      beat_cnt <= word_full ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_layer1_weight_loader.sv
// sram_layer1_weight_loader: streams weights into the layer-1 SRAM set bank.
// Packs BIT_WIDTH_SRAM/IN_WIDTH beats per word and writes words in set-major
// order (set 0 addr 0..DEPTH_SRAM-1, then set 1, ...).
// Optional build macro WEIGHT_LOADER_CHECKSUM_EN adds checksum_o.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start_i                begin a full load (only honoured in IDLE)
//   abort_i                return to IDLE, partial word discarded
//   in_valid_i/in_data_i   stream beat, taken when in_ready_o is high
//   in_ready_o             high while loading
//   port1_address_o        per-set address slices, zero when not selected
//   port1_enable_o         one-hot write strobe during the write cycle
//   port1_write_enable_o   same as port1_enable_o
//   port1_write_data_o     per-set data slices, zero when not selected
//   busy_o                 high in LOAD or WRITE
//   done_o                 one-cycle pulse after the final word
//   checksum_o             (macro only) 16-bit sum of accepted weight fields
module sram_layer1_weight_loader
  import sram_layer1_weight_loader_pkg::*;
#(
  parameter int BIT_WIDTH_WEIGHT  = 8,
  parameter int BIT_WIDTH_SRAM    = 160,
  parameter int DEPTH_SRAM        = 980,
  parameter int BIT_WIDTH_ADDRESS = 10,
  parameter int SET_NUM           = 10,
  parameter int IN_WIDTH          = 32
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start_i,
  input  logic                                  abort_i,
  input  logic                                  in_valid_i,
  input  logic [IN_WIDTH-1:0]                   in_data_i,
  output logic                                  in_ready_o,
  output logic [BIT_WIDTH_ADDRESS*SET_NUM-1:0]  port1_address_o,
  output logic [SET_NUM-1:0]                    port1_enable_o,
  output logic [SET_NUM-1:0]                    port1_write_enable_o,
  output logic [BIT_WIDTH_SRAM*SET_NUM-1:0]     port1_write_data_o,
  output logic                                  busy_o,
  output logic                                  done_o
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                           checksum_o
`endif
);

  localparam int BEATS = beats_of(BIT_WIDTH_SRAM, IN_WIDTH);
  localparam int SET_W = cnt_width(SET_NUM);

  generate
    if ((BIT_WIDTH_SRAM % IN_WIDTH) != 0 || BEATS < 1 || BIT_WIDTH_WEIGHT < 1) begin : g_width_check
      $error("sram_layer1_weight_loader: BIT_WIDTH_SRAM must be a nonzero multiple of IN_WIDTH");
    end
  endgenerate

  state_t                       state;
  state_t                       state_next;
  logic [BIT_WIDTH_ADDRESS-1:0] addr_cnt;
  logic [SET_W-1:0]             set_cnt;
  logic                         accept;
  logic                         start_load;
  logic                         clear;
  logic                         word_full;
  logic                         last_word;
  logic                         issue_write;
  logic [BIT_WIDTH_SRAM-1:0]    word;

  assign in_ready_o  = (state == ST_LOAD);
  assign busy_o      = (state == ST_LOAD) || (state == ST_WRITE);
  assign done_o      = (state == ST_DONE);
  assign accept      = in_valid_i && in_ready_o;
  assign start_load  = (state == ST_IDLE) && start_i;
  assign clear       = abort_i || start_load;
  assign issue_write = word_full && !abort_i;
  assign last_word   = (set_cnt == SET_W'(SET_NUM - 1)) &&
                       (addr_cnt == BIT_WIDTH_ADDRESS'(DEPTH_SRAM - 1));

  assign port1_write_enable_o = port1_enable_o;

  weight_beat_packer #(
    .IN_WIDTH   (IN_WIDTH),
    .WORD_WIDTH (BIT_WIDTH_SRAM)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .accept    (accept),
    .data      (in_data_i),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_next = state;
    if (abort_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_i) state_next = ST_LOAD;
        ST_LOAD:  if (word_full) state_next = ST_WRITE;
        ST_WRITE: state_next = last_word ? ST_DONE : ST_LOAD;
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address/set counters advance once per completed write cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt <= '0;
      set_cnt  <= '0;
    end else if (clear) begin
      addr_cnt <= '0;
      set_cnt  <= '0;
    end else if (state == ST_WRITE) begin
      if (addr_cnt == BIT_WIDTH_ADDRESS'(DEPTH_SRAM - 1)) begin
        addr_cnt <= '0;
        set_cnt  <= set_cnt + 1'b1;
      end else begin
        addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

  // Port registers: loaded on the edge that takes the last beat so the strobe
  // is visible during WRITE, and cleared every other cycle so unselected
  // slices never carry stale values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port1_enable_o     <= '0;
      port1_address_o    <= '0;
      port1_write_data_o <= '0;
    end else begin
      port1_enable_o     <= '0;
      port1_address_o    <= '0;
      port1_write_data_o <= '0;
      if (issue_write) begin
        port1_enable_o[set_cnt]                                           <= 1'b1;
        port1_address_o[set_cnt*BIT_WIDTH_ADDRESS +: BIT_WIDTH_ADDRESS]   <= addr_cnt;
        port1_write_data_o[set_cnt*BIT_WIDTH_SRAM +: BIT_WIDTH_SRAM]      <= word;
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int FIELDS = IN_WIDTH / BIT_WIDTH_WEIGHT;

  logic [15:0] beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < FIELDS; i++) begin
      beat_sum = beat_sum + 16'(in_data_i[i*BIT_WIDTH_WEIGHT +: BIT_WIDTH_WEIGHT]);
    end
  end

  // Beats dropped by a coincident abort are not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_o <= '0;
    end else if (start_load) begin
      checksum_o <= '0;
    end else if (accept && !abort_i) begin
      checksum_o <= checksum_o + beat_sum;
    end
  end
`endif

endmodule

// File: tb/tb_sram_layer1_weight_loader.sv
// Self-checking bench for sram_layer1_weight_loader (DEPTH_SRAM=4, SET_NUM=2,
// IN_WIDTH=32). Optional macro WEIGHT_LOADER_CHECKSUM_EN enables checksum checks.
module tb_sram_layer1_weight_loader;

  localparam int SW    = 160;
  localparam int IW    = 32;
  localparam int D     = 4;
  localparam int SN    = 2;
  localparam int AW    = 10;
  localparam int BEATS = SW / IW;
  localparam int NW    = D * SN;

  logic              clk;
  logic              reset_n;
  logic              start_i;
  logic              abort_i;
  logic              in_valid_i;
  logic [IW-1:0]     in_data_i;
  logic              in_ready_o;
  logic [AW*SN-1:0]  addr;
  logic [SN-1:0]     en;
  logic [SN-1:0]     we;
  logic [SW*SN-1:0]  wdata;
  logic              busy_o;
  logic              done_o;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
  logic [15:0]       cksum_at_done;
`endif

  sram_layer1_weight_loader #(
    .BIT_WIDTH_WEIGHT  (8),
    .BIT_WIDTH_SRAM    (SW),
    .DEPTH_SRAM        (D),
    .BIT_WIDTH_ADDRESS (AW),
    .SET_NUM           (SN),
    .IN_WIDTH          (IW)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start_i              (start_i),
    .abort_i              (abort_i),
    .in_valid_i           (in_valid_i),
    .in_data_i            (in_data_i),
    .in_ready_o           (in_ready_o),
    .port1_address_o      (addr),
    .port1_enable_o       (en),
    .port1_write_enable_o (we),
    .port1_write_data_o   (wdata),
    .busy_o               (busy_o),
    .done_o               (done_o)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    .checksum_o           (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [IW-1:0] beats_q[$];
  int            wr_set[$];
  int            wr_addr[$];
  int            wr_cyc[$];
  logic [SW-1:0] wr_data[$];
  int            done_cnt;
  int            done_cyc;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Port monitor: records every write strobe and checks bus hygiene.
  always @(negedge clk) begin
    chk("we_equals_en", we, en);
    if (en != '0) begin
      chk("en_onehot", $onehot(en), 1);
      for (int s = 0; s < SN; s++) begin
        if (en[s]) begin
          wr_set.push_back(s);
          wr_addr.push_back(int'(addr[s*AW +: AW]));
          wr_data.push_back(wdata[s*SW +: SW]);
          wr_cyc.push_back(cyc);
        end else begin
          chk("idle_slice_addr", addr[s*AW +: AW], 0);
          chk("idle_slice_data", wdata[s*SW +: SW], 0);
        end
      end
    end else begin
      chk("nowrite_addr", addr, 0);
      chk("nowrite_data", wdata, 0);
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      cksum_at_done = checksum;
`endif
    end
  end

  task automatic begin_run();
    beats_q.delete();
    wr_set.delete();
    wr_addr.delete();
    wr_cyc.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // mode: 0 valid held high, 1 valid every other cycle, 2 random valid
  // kind: 0 random data, 1 counting 1,2,3..., 2 constant 0x01010101
  task automatic send(input int n, input int mode, input int kind);
    bit toggle = 1'b1;
    for (int b = 0; b < n; b++) begin
      logic [IW-1:0] d;
      bit            acc = 1'b0;
      int            guard = 0;
      logic          rdy;
      case (kind)
        1:       d = IW'(beats_q.size() + 1);
        2:       d = 32'h01010101;
        default: d = $urandom;
      endcase
      in_data_i = d;
      while (!acc) begin
        case (mode)
          0:       in_valid_i = 1'b1;
          1:       in_valid_i = toggle;
          default: in_valid_i = 1'($urandom_range(0, 1));
        endcase
        toggle = ~toggle;
        @(negedge clk);
        rdy = in_ready_o;
        @(posedge clk); #1;
        if (in_valid_i && rdy) acc = 1'b1;
        guard++;
        if (!acc && guard > 60) begin
          chk("send_timeout", 0, 1);
          in_valid_i = 1'b0;
          return;
        end
      end
      beats_q.push_back(d);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt == 0 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_cksum();
    logic [15:0] s = '0;
    foreach (beats_q[i])
      for (int j = 0; j < IW / 8; j++) s = s + 16'(beats_q[i][j*8 +: 8]);
    return s;
  endfunction

  // Reference: word k is beats 5k..5k+4 LSB-first, at set k/D, addr k%D.
  task automatic verify(input string tag, input bit expect_done, input bit check_rate);
    int nw = beats_q.size() / BEATS;
    if (nw > NW) nw = NW;
    chk({tag, "_nwrites"}, wr_set.size(), nw);
    for (int k = 0; k < nw && k < wr_set.size(); k++) begin
      logic [SW-1:0] w = '0;
      for (int j = 0; j < BEATS; j++) w[j*IW +: IW] = beats_q[k*BEATS + j];
      chk({tag, "_set"}, wr_set[k], k / D);
      chk({tag, "_addr"}, wr_addr[k], k % D);
      chk({tag, "_data"}, wr_data[k], w);
      if (check_rate && k > 0) chk({tag, "_spacing"}, wr_cyc[k] - wr_cyc[k-1], BEATS + 1);
    end
    chk({tag, "_done_count"}, done_cnt, expect_done ? 1 : 0);
    if (expect_done && wr_cyc.size() > 0 && done_cnt > 0)
      chk({tag, "_done_latency"}, done_cyc - wr_cyc[wr_cyc.size()-1], 1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    if (expect_done) begin
      chk({tag, "_cksum_done"}, cksum_at_done, model_cksum());
      chk({tag, "_cksum_held"}, checksum, model_cksum());
    end
`endif
  endtask

  initial begin
    reset_n    = 1'b1;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    done_cnt   = 0;
    done_cyc   = 0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_en", en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", wdata, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("rst_cksum", checksum, 0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", in_ready_o, 0);

    // Directed counting stream, valid held high.
    begin_run();
    pulse_start();
    chk("load_busy", busy_o, 1);
    chk("load_ready", in_ready_o, 1);
    send(NW * BEATS, 0, 1);
    wait_done();
    verify("count", 1'b1, 1'b1);
    if (wr_set.size() == NW) begin
      chk("first_set", wr_set[0], 0);
      chk("first_addr", wr_addr[0], 0);
      chk("first_word", wr_data[0], 160'h00000005_00000004_00000003_00000002_00000001);
      chk("last_set", wr_set[NW-1], 1);
      chk("last_addr", wr_addr[NW-1], 3);
    end
    chk("after_done_busy", busy_o, 0);

    // Random data, valid toggling every other cycle.
    begin_run();
    pulse_start();
    send(NW * BEATS, 1, 0);
    wait_done();
    verify("toggle", 1'b1, 1'b0);

    // Random data, random valid.
    begin_run();
    pulse_start();
    send(NW * BEATS, 2, 0);
    wait_done();
    verify("randvalid", 1'b1, 1'b0);

    // Abort after two beats of the third word.
    begin_run();
    pulse_start();
    send(2 * BEATS + 2, 0, 0);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", in_ready_o, 0);
    repeat (3) @(posedge clk);
    #1;
    verify("abort", 1'b0, 1'b0);
    begin_run();
    pulse_start();
    send(NW * BEATS, 2, 0);
    wait_done();
    verify("after_abort", 1'b1, 1'b0);

    // start_i during LOAD is ignored.
    begin_run();
    pulse_start();
    send(7, 0, 0);
    pulse_start();
    @(negedge clk);
    chk("start_in_load_busy", busy_o, 1);
    @(posedge clk); #1;
    send(NW * BEATS - 7, 0, 0);
    wait_done();
    verify("start_in_load", 1'b1, 1'b0);

    // Asynchronous reset in the middle of a word.
    begin_run();
    pulse_start();
    send(3, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_ready", in_ready_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_en", en, 0);
    chk("arst_addr", addr, 0);
    chk("arst_data", wdata, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_ready_hold", in_ready_o, 0);
    chk("arst_busy_hold", busy_o, 0);
    verify("arst", 1'b0, 1'b0);
    begin_run();
    pulse_start();
    send(NW * BEATS, 1, 0);
    wait_done();
    verify("after_arst", 1'b1, 1'b0);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    begin_run();
    pulse_start();
    chk("cksum_cleared", checksum, 0);
    send(NW * BEATS, 0, 2);
    wait_done();
    verify("cksum", 1'b1, 1'b1);
    chk("cksum_160", cksum_at_done, 160);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_layer1_weight_loader.md
Name: sram_layer1_weight_loader

Overview:
- Upstream loader for the layer-1 weight SRAM set bank (SET_NUM banks, each DEPTH_SRAM words × BIT_WIDTH_SRAM bits).
- Accepts a narrow weight stream over a valid/ready handshake and packs BEATS = BIT_WIDTH_SRAM/IN_WIDTH beats into one SRAM word.
- Issues one-hot per-set write strobes, walking addresses in set-major order: set 0 addr 0..DEPTH_SRAM-1, then set 1, and so on.
- Drives the bank's flattened port1 address, enable, write-enable and write-data buses directly.

Parameters:
- BIT_WIDTH_WEIGHT, 8, bits per weight (informational; packing is IN_WIDTH-granular).
- BIT_WIDTH_SRAM, 160, SRAM word width.
- DEPTH_SRAM, 980, words per set.
- BIT_WIDTH_ADDRESS, 10, SRAM address width.
- SET_NUM, 10, number of SRAM sets.
- IN_WIDTH, 32, stream beat width; BIT_WIDTH_SRAM % IN_WIDTH must be 0 (elaboration-time check).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that begins a full load; ignored unless IDLE.
- abort_i  in  1  return to IDLE; any partial word is discarded.
- in_valid_i  in  1  stream beat valid.
- in_data_i  in  IN_WIDTH  stream beat.
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o.
- port1_address_o  out  BIT_WIDTH_ADDRESS*SET_NUM  per-set address; zero for non-selected sets.
- port1_enable_o  out  SET_NUM  one-hot during a write cycle, else 0.
- port1_write_enable_o  out  SET_NUM  equals port1_enable_o.
- port1_write_data_o  out  BIT_WIDTH_SRAM*SET_NUM  packed word in the selected slice; other slices zero.
- busy_o  out  1  high in LOAD or WRITE.
- done_o  out  1  one-cycle pulse after the final word is written.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - beat_cnt, addr_cnt, set_cnt and pack register cleared.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready_o = 0.
  - start_i moves to LOAD and clears all counters.
- LOAD:
  - in_ready_o = 1.
  - Each accepted beat writes pack[beat_cnt*IN_WIDTH +: IN_WIDTH]; first beat goes to the LSBs.
  - beat_cnt increments per accepted beat.
  - On the beat with beat_cnt == BEATS-1: go to WRITE and reset beat_cnt to 0.
- WRITE (exactly one cycle):
  - Port outputs are registered: the write strobe appears the cycle after the last beat is accepted.
  - in_ready_o = 0.
  - Asserts port1_enable_o[set_cnt] and port1_write_enable_o[set_cnt].
  - Drives addr_cnt and the pack word into slice set_cnt.
  - Then advances addr_cnt. At DEPTH_SRAM-1, addr_cnt wraps to 0 and set_cnt increments.
  - After the final word (set_cnt == SET_NUM-1, addr_cnt == DEPTH_SRAM-1): go to DONE; otherwise back to LOAD.
- DONE: done_o = 1 for one cycle, then IDLE.
- Write-cycle outputs return to 0 on the next cycle; there are no glitches on non-selected slices.
- Throughput: BEATS+1 cycles per word when in_valid_i is held high.
- abort_i:
  - Highest priority in every state; next state IDLE, counters cleared, no write issued.
  - If abort_i coincides with the WRITE cycle, that write still completes (it is already registered) and abort takes effect the following cycle.
- start_i while busy: ignored.
- in_valid_i low mid-word: packing stalls with no timeout.
- Asynchronous reset mid-load: immediate return to the reset state; SRAM contents are not restored.

Optional Feature:
- Macro: WEIGHT_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum_o [15:0]: the modular sum of all accepted BIT_WIDTH_WEIGHT-bit fields, treated as unsigned.
  - Cleared on start_i and on reset; held stable from done_o until the next start_i.
- When undefined: the port and its logic are absent.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/LOAD/WRITE/DONE).
  - BEATS = BIT_WIDTH_SRAM/IN_WIDTH, with its counter width $clog2(BEATS).
  - $clog2(SET_NUM) counter width.
- Sub-module weight_beat_packer: the pack register plus beat_cnt, raising word_full. The top holds the FSM, address/set counters and output slicing.

Test Plan (bench overrides DEPTH_SRAM=4, SET_NUM=2, IN_WIDTH=32):
- Reset then a continuous stream of beats 0x00000001..0x00000028 (40 beats) -> 8 writes.
  - First write: set 0, addr 0, word = {5,4,3,2,1}.
  - Last write: set 1, addr 3.
  - done_o pulses 1 cycle after the last write.
- in_valid_i toggling every other cycle -> words and addresses identical to the continuous case, with write strobes spaced accordingly.
- abort_i after 2 beats of word 3 -> no write for word 3, IDLE next cycle. A following start_i restarts at set 0, addr 0.
- start_i pulsed during LOAD -> ignored; counters are unchanged.
- reset_n low for 1 cycle mid-word -> all outputs 0 asynchronously; in_ready_o stays 0 until start_i.
- WEIGHT_LOADER_CHECKSUM_EN defined, 40 beats of 0x01010101 -> checksum_o = 160 at done_o.
